complex_frame_accumulator: RTL and testbench

//  Multi-channel complex accumulator for the convolution/FFT datapath.

---
 rtl/complex_frame_accumulator_if.sv | 57 +++++
 rtl/complex_frame_accumulator.sv | 222 ++++++++++++++++++++++
 tb/tb_complex_frame_accumulator.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/complex_frame_accumulator_if.sv
// -----------------------------------------------------------------------------
// complex_frame_accumulator_if
//   Bundles the frame-control, sample-input and result-output signals of
//   complex_frame_accumulator. clk and reset stay plain ports on the block.
//
//   Handshake semantics (both streams): a transfer happens on a rising clock
//   edge where valid and ready are both high. The producer holds its payload
//   stable while valid is high and ready is low; ready never depends on valid.
//
//   Signals (direction as seen by the accumulator, modport slave):
//     start      in   begin frame (honoured only while idle)
//     frame_len  in   samples per channel, captured on accepted start
//     in_valid   in   input beat valid
//     in_ready   out  high only while accumulating
//     in_r/in_i  in   signed sample, DATA_W bits
//     out_valid  out  result valid while draining
//     out_ready  in   consumer accepts result
//     out_ch     out  channel index of out_r/out_i
//     out_r/out_i out signed channel sums, ACC_W bits
//     busy       out  block not idle
//     done       out  one-cycle pulse after last result accepted
//     overflow   out  sticky saturation flag (saturating build only)
// -----------------------------------------------------------------------------
interface complex_frame_accumulator_if #(
    parameter int DATA_W  = 32,
    parameter int ACC_W   = 40,
    parameter int NUM_CH  = 4,
    parameter int MAX_LEN = 1024
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              start;
    logic [LEN_W-1:0]  frame_len;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_r;
    logic [DATA_W-1:0] in_i;
    logic              out_valid;
    logic              out_ready;
    logic [CH_W-1:0]   out_ch;
    logic [ACC_W-1:0]  out_r;
    logic [ACC_W-1:0]  out_i;
    logic              busy;
    logic              done;
    logic              overflow;

    modport master (
        output start, frame_len, in_valid, in_r, in_i, out_ready,
        input  in_ready, out_valid, out_ch, out_r, out_i, busy, done, overflow
    );

    modport slave (
        input  start, frame_len, in_valid, in_r, in_i, out_ready,
        output in_ready, out_valid, out_ch, out_r, out_i, busy, done, overflow
    );
endinterface

// File: rtl/complex_frame_accumulator.sv
// -----------------------------------------------------------------------------
// complex_frame_accumulator
//   Multi-channel complex accumulator. Samples arrive channel-interleaved
//   round-robin (ch0..chN-1, ch0..). Each channel is summed over frame_len
//   samples, then the sums are drained one channel per output handshake.
//
//   Optional feature: define SAT_EN to make every add saturate to the signed
//   ACC_W range and raise a sticky overflow flag. Without SAT_EN the adds wrap
//   modulo 2^ACC_W and overflow is tied low. Ports are identical in both builds.
//
//   Ports:
//     clk        clock, everything on posedge
//     reset      synchronous, active-high; abandons any frame without done
//     bus        complex_frame_accumulator_if.slave (see interface header)
//     dbg_state  current FSM state (0 idle, 1 accumulate, 2 drain)
// -----------------------------------------------------------------------------
module complex_frame_accumulator #(
    parameter int DATA_W  = 32,
    parameter int ACC_W   = 40,
    parameter int NUM_CH  = 4,
    parameter int MAX_LEN = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    complex_frame_accumulator_if.slave   bus,
    output logic [1:0]                   dbg_state
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    logic [1:0]       state_q,   state_d;
    logic [CH_W-1:0]  ch_ptr_q,  ch_ptr_d;
    logic [LEN_W-1:0] smp_cnt_q, smp_cnt_d;
    logic [LEN_W-1:0] len_q,     len_d;
    logic [CH_W-1:0]  out_ch_q,  out_ch_d;
    logic             done_q,    done_d;
    logic [ACC_W-1:0] acc_r_q [NUM_CH];
    logic [ACC_W-1:0] acc_r_d [NUM_CH];
    logic [ACC_W-1:0] acc_i_q [NUM_CH];
    logic [ACC_W-1:0] acc_i_d [NUM_CH];

    logic [ACC_W-1:0] ext_r, ext_i;
    logic [ACC_W-1:0] sel_r, sel_i;
    logic             beat;
    logic             out_fire;

`ifdef SAT_EN
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   sum_r, sum_i;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Returns {saturated, result}. The sum is formed one bit wider so that a
    // disagreement between the two top bits marks a signed overflow; the top
    // bit then gives the true sign and picks the clamp value.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1]) begin
            return {1'b1, (s[ACC_W] ? ACC_MIN : ACC_MAX)};
        end
        return {1'b0, s[ACC_W-1:0]};
    endfunction
`else
    // Plain two's-complement add; carry out of the top bit is dropped (wrap).
    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        return a + b;
    endfunction
`endif

    // Size cast of a signed value sign-extends into the guard bits.
    assign ext_r = ACC_W'($signed(bus.in_r));
    assign ext_i = ACC_W'($signed(bus.in_i));

    assign beat     = bus.in_valid && (state_q == S_ACCUM);
    assign out_fire = bus.out_ready && (state_q == S_DRAIN);

    always_comb begin
        state_d   = state_q;
        ch_ptr_d  = ch_ptr_q;
        smp_cnt_d = smp_cnt_q;
        len_d     = len_q;
        out_ch_d  = out_ch_q;
        done_d    = 1'b0;
        acc_r_d   = acc_r_q;
        acc_i_d   = acc_i_q;
`ifdef SAT_EN
        ovf_d     = ovf_q;
        sum_r     = '0;
        sum_i     = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        acc_r_d[k] = '0;
                        acc_i_d[k] = '0;
                    end
                    ch_ptr_d  = '0;
                    smp_cnt_d = '0;
                    out_ch_d  = '0;
                    len_d     = bus.frame_len;
`ifdef SAT_EN
                    ovf_d     = 1'b0;
`endif
                    // An empty frame skips accumulation and drains zeros.
                    state_d   = (bus.frame_len == '0) ? S_DRAIN : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (beat) begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (ch_ptr_q == CH_W'(k)) begin
`ifdef SAT_EN
                            sum_r      = acc_add(acc_r_q[k], ext_r);
                            sum_i      = acc_add(acc_i_q[k], ext_i);
                            acc_r_d[k] = sum_r[ACC_W-1:0];
                            acc_i_d[k] = sum_i[ACC_W-1:0];
                            ovf_d      = ovf_q | sum_r[ACC_W] | sum_i[ACC_W];
`else
                            acc_r_d[k] = acc_add(acc_r_q[k], ext_r);
                            acc_i_d[k] = acc_add(acc_i_q[k], ext_i);
`endif
                        end
                    end
                    if (ch_ptr_q == LAST_CH) begin
                        ch_ptr_d  = '0;
                        smp_cnt_d = smp_cnt_q + LEN_W'(1);
                        // Last channel of the last sample group closes the frame.
                        if (smp_cnt_q == len_q - LEN_W'(1)) begin
                            state_d  = S_DRAIN;
                            out_ch_d = '0;
                        end
                    end else begin
                        ch_ptr_d = ch_ptr_q + CH_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (out_fire) begin
                    if (out_ch_q == LAST_CH) begin
                        out_ch_d = '0;
                        state_d  = S_IDLE;
                        done_d   = 1'b1;
                    end else begin
                        out_ch_d = out_ch_q + CH_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Result mux reads the accumulator registers directly, so the payload is
    // stable for as long as the consumer stalls.
    always_comb begin
        sel_r = '0;
        sel_i = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (out_ch_q == CH_W'(k)) begin
                sel_r = acc_r_q[k];
                sel_i = acc_i_q[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ch_ptr_q  <= '0;
            smp_cnt_q <= '0;
            len_q     <= '0;
            out_ch_q  <= '0;
            done_q    <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                acc_r_q[k] <= '0;
                acc_i_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ch_ptr_q  <= ch_ptr_d;
            smp_cnt_q <= smp_cnt_d;
            len_q     <= len_d;
            out_ch_q  <= out_ch_d;
            done_q    <= done_d;
            acc_r_q   <= acc_r_d;
            acc_i_q   <= acc_i_d;
        end
    end

`ifdef SAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
    assign bus.overflow = ovf_q;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.in_ready  = (state_q == S_ACCUM);
    assign bus.out_valid = (state_q == S_DRAIN);
    assign bus.out_ch    = out_ch_q;
    assign bus.out_r     = sel_r;
    assign bus.out_i     = sel_i;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_complex_frame_accumulator.sv
// -----------------------------------------------------------------------------
// tb_complex_frame_accumulator
//   Three instances: a 4-channel 32/40-bit block driven from a table of frames,
//   a 1-channel 32/40-bit block, and a 1-channel 8/9-bit block that exercises
//   wrap versus saturation (expected values follow the SAT_EN build macro).
//   All stimulus and sampling happens on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_complex_frame_accumulator;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] dbg4, dbg1, dbg8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  complex_frame_accumulator_if #(.DATA_W(32), .ACC_W(40), .NUM_CH(4), .MAX_LEN(1024)) b4 ();
  complex_frame_accumulator_if #(.DATA_W(32), .ACC_W(40), .NUM_CH(1), .MAX_LEN(1024)) b1 ();
  complex_frame_accumulator_if #(.DATA_W(8),  .ACC_W(9),  .NUM_CH(1), .MAX_LEN(16))   b8 ();

  complex_frame_accumulator #(.DATA_W(32), .ACC_W(40), .NUM_CH(4), .MAX_LEN(1024)) dut4 (
    .clk(clk), .reset(reset), .bus(b4), .dbg_state(dbg4));
  complex_frame_accumulator #(.DATA_W(32), .ACC_W(40), .NUM_CH(1), .MAX_LEN(1024)) dut1 (
    .clk(clk), .reset(reset), .bus(b1), .dbg_state(dbg1));
  complex_frame_accumulator #(.DATA_W(8), .ACC_W(9), .NUM_CH(1), .MAX_LEN(16)) dut8 (
    .clk(clk), .reset(reset), .bus(b8), .dbg_state(dbg8));

  typedef struct packed {
    logic [10:0]       len;
    logic [3:0][31:0]  r;      // per-channel sample, index = channel
    logic [3:0][31:0]  im;
    logic [3:0][39:0]  er;     // hand-computed channel sums
    logic [3:0][39:0]  ei;
    logic              stall;  // hold out_ready low 5 cycles per result
    logic [1:0]        gap;    // max random idle cycles before each beat
  } vec_t;

  vec_t tbl [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start4(input logic [10:0] len);
    b4.start = 1'b1;
    b4.frame_len = len;
    @(negedge clk);
    b4.start = 1'b0;
    check("start_busy", b4.busy, 1);
  endtask

  task automatic send4(input logic [31:0] r, input logic [31:0] i);
    int t = 0;
    b4.in_valid = 1'b1;
    b4.in_r = r;
    b4.in_i = i;
    while (!b4.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_wait", b4.in_ready, 1);
    @(negedge clk);
    b4.in_valid = 1'b0;
  endtask

  task automatic drain4(input logic [3:0][39:0] er, input logic [3:0][39:0] ei, input bit stall);
    for (int k = 0; k < 4; k++) begin
      int t = 0;
      while (!b4.out_valid && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("out_valid_wait", b4.out_valid, 1);
      check("drain_ch", b4.out_ch, 64'(k));
      check("drain_r", b4.out_r, er[k]);
      check("drain_i", b4.out_i, ei[k]);
      check("drain_done_low", b4.done, 0);
      if (stall) begin
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check("stall_valid", b4.out_valid, 1);
          check("stall_ch", b4.out_ch, 64'(k));
          check("stall_r", b4.out_r, er[k]);
          check("stall_i", b4.out_i, ei[k]);
          check("stall_in_ready", b4.in_ready, 0);
        end
      end
      b4.out_ready = 1'b1;
      @(negedge clk);
      b4.out_ready = 1'b0;
    end
    check("done_pulse", b4.done, 1);
    check("idle_after_drain", b4.busy, 0);
  endtask

  task automatic run_row(input vec_t v);
    start4(v.len);
    for (int s = 0; s < int'(v.len); s++) begin
      for (int k = 0; k < 4; k++) begin
        repeat ($urandom_range(0, int'(v.gap))) @(negedge clk);
        send4(v.r[k], v.im[k]);
      end
    end
    check("valid_after_last", b4.out_valid, 1);
    drain4(v.er, v.ei, v.stall);
    @(negedge clk);
    check("done_one_cycle", b4.done, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Row 0: ch k gets (k+1) - j(k+1) twice, random gaps.
    tbl[0].len = 11'd2;
    tbl[0].r   = {32'd4, 32'd3, 32'd2, 32'd1};
    tbl[0].im  = {-32'sd4, -32'sd3, -32'sd2, -32'sd1};
    tbl[0].er  = {40'd8, 40'd6, 40'd4, 40'd2};
    tbl[0].ei  = {-40'sd8, -40'sd6, -40'sd4, -40'sd2};
    tbl[0].stall = 1'b0;
    tbl[0].gap   = 2'd2;
    // Row 1: extreme 32-bit values need the guard bits; stalled drain.
    tbl[1].len = 11'd3;
    tbl[1].r   = {32'd5, -32'sd1, 32'h8000_0000, 32'h7FFF_FFFF};
    tbl[1].im  = {32'h4000_0000, -32'sd1000, 32'd1000, 32'd0};
    tbl[1].er  = {40'sd15, -40'sd3, -40'sd6442450944, 40'sd6442450941};
    tbl[1].ei  = {40'sd3221225472, -40'sd3000, 40'sd3000, 40'sd0};
    tbl[1].stall = 1'b1;
    tbl[1].gap   = 2'd0;
    // Row 2: single sample per channel.
    tbl[2].len = 11'd1;
    tbl[2].r   = {32'd40, 32'd30, 32'd20, 32'd10};
    tbl[2].im  = {32'd1, 32'd5, 32'd0, -32'sd5};
    tbl[2].er  = {40'd40, 40'd30, 40'd20, 40'd10};
    tbl[2].ei  = {40'd1, 40'd5, 40'd0, -40'sd5};
    tbl[2].stall = 1'b0;
    tbl[2].gap   = 2'd1;
    // Row 3: empty frame drains zeros.
    tbl[3].len = 11'd0;
    tbl[3].r   = '0;
    tbl[3].im  = '0;
    tbl[3].er  = '0;
    tbl[3].ei  = '0;
    tbl[3].stall = 1'b0;
    tbl[3].gap   = 2'd0;

    // Clock/reset
    reset = 1'b1;
    b4.start = 0; b4.frame_len = '0; b4.in_valid = 0; b4.in_r = '0; b4.in_i = '0; b4.out_ready = 0;
    b1.start = 0; b1.frame_len = '0; b1.in_valid = 0; b1.in_r = '0; b1.in_i = '0; b1.out_ready = 0;
    b8.start = 0; b8.frame_len = '0; b8.in_valid = 0; b8.in_r = '0; b8.in_i = '0; b8.out_ready = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", b4.busy, 0);
    check("rst_in_ready", b4.in_ready, 0);
    check("rst_out_valid", b4.out_valid, 0);
    check("rst_done", b4.done, 0);
    check("rst_overflow", b4.overflow, 0);
    check("rst_out_r", b4.out_r, 0);
    check("rst_out_ch", b4.out_ch, 0);
    check("rst_state", dbg4, 0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven frames on the 4-channel block.
    for (int n = 0; n < 4; n++) run_row(tbl[n]);

    // Single channel, contiguous 100..103 on both parts.
    b1.start = 1'b1; b1.frame_len = 11'd4;
    @(negedge clk);
    b1.start = 1'b0;
    check("c1_in_ready", b1.in_ready, 1);
    b1.in_valid = 1'b1;
    for (int v = 100; v < 104; v++) begin
      b1.in_r = 32'(v);
      b1.in_i = 32'(v);
      @(negedge clk);
    end
    b1.in_valid = 1'b0;
    check("c1_out_valid", b1.out_valid, 1);
    check("c1_out_ch", b1.out_ch, 0);
    check("c1_out_r", b1.out_r, 40'd406);
    check("c1_out_i", b1.out_i, 40'd406);
    b1.out_ready = 1'b1;
    @(negedge clk);
    b1.out_ready = 1'b0;
    check("c1_done", b1.done, 1);
    check("c1_idle", b1.busy, 0);
    @(negedge clk);
    check("c1_done_clear", b1.done, 0);

    // Narrow block: 127 x4 real, -128 x4 imag.
    b8.start = 1'b1; b8.frame_len = 5'd4;
    @(negedge clk);
    b8.start = 1'b0;
    b8.in_valid = 1'b1;
    b8.in_r = 8'sd127;
    b8.in_i = 8'h80;
    repeat (4) @(negedge clk);
    b8.in_valid = 1'b0;
    check("n8_out_valid", b8.out_valid, 1);
`ifdef SAT_EN
    check("n8_out_r", b8.out_r, 9'h0FF);
    check("n8_out_i", b8.out_i, 9'h100);
    check("n8_overflow", b8.overflow, 1);
`else
    check("n8_out_r", b8.out_r, 9'h1FC);
    check("n8_out_i", b8.out_i, 9'h000);
    check("n8_overflow", b8.overflow, 0);
`endif
    b8.out_ready = 1'b1;
    @(negedge clk);
    b8.out_ready = 1'b0;
    check("n8_done", b8.done, 1);
    // Next frame clears the sticky flag.
    b8.start = 1'b1; b8.frame_len = 5'd1;
    @(negedge clk);
    b8.start = 1'b0;
    b8.in_valid = 1'b1;
    b8.in_r = 8'd1;
    b8.in_i = 8'd1;
    @(negedge clk);
    b8.in_valid = 1'b0;
    check("n8b_out_r", b8.out_r, 9'd1);
    check("n8b_overflow", b8.overflow, 0);
    b8.out_ready = 1'b1;
    @(negedge clk);
    b8.out_ready = 1'b0;

    // Start during accumulation is ignored, as is the new frame_len.
    start4(11'd1);
    send4(32'd1, 32'd0);
    send4(32'd2, 32'd0);
    b4.start = 1'b1; b4.frame_len = 11'd5;
    @(negedge clk);
    b4.start = 1'b0;
    check("ign_state", dbg4, 1);
    check("ign_in_ready", b4.in_ready, 1);
    send4(32'd3, 32'd0);
    send4(32'd4, 32'd0);
    check("ign_drain_now", b4.out_valid, 1);
    drain4({40'd4, 40'd3, 40'd2, 40'd1}, '0, 1'b0);

    // Start in the done cycle is accepted.
    b4.start = 1'b1; b4.frame_len = 11'd1;
    @(negedge clk);
    b4.start = 1'b0;
    check("done_start_busy", b4.busy, 1);
    check("done_start_ready", b4.in_ready, 1);
    send4(32'd50, 32'd50);
    send4(32'd50, 32'd50);

    // Reset mid-accumulation discards the partial frame without done.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", b4.busy, 0);
    check("mid_rst_done", b4.done, 0);
    check("mid_rst_in_ready", b4.in_ready, 0);
    @(negedge clk);
    check("mid_rst_done2", b4.done, 0);
    start4(11'd1);
    for (int k = 0; k < 4; k++) send4(32'd7, 32'd7);
    check("post_rst_valid", b4.out_valid, 1);
    drain4({4{40'd7}}, {4{40'd7}}, 1'b0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
